// File: rtl/load_store_unit.sv
// load_store_unit: converts byte/half/word load and store requests into
// whole-word memory accesses. Sub-word stores are read-modify-write; loads
// are sign- or zero-extended. One request in flight at a time.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic                  i_req_wr,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [31:0]           i_req_wr_val,
  output logic                  o_rsp_valid,
  output logic [31:0]           o_rsp_val,
  output logic                  o_rsp_err,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_wr_en,
  output logic [31:0]           o_mem_wr_val,
  input  logic [31:0]           i_mem_val
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_r;
  logic        wr_r;
  logic [1:0]  size_r;
  logic        uns_r;
  logic [31:0] wv_r;

  // Extend the low byte/half of a read word; word passes through.
  function automatic logic [31:0] extend_load(input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [31:0] res;
    case (size)
      2'b00:   res = uns ? {24'd0, data[7:0]}  : {{24{data[7]}}, data[7:0]};
      2'b01:   res = uns ? {16'd0, data[15:0]} : {{16{data[15]}}, data[15:0]};
      2'b10:   res = data;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Merge store data into the word just read; the upper bytes are written
  // back with their current values so memory is unchanged there.
  function automatic logic [31:0] merge_store(input logic [31:0] rdata,
                                              input logic [31:0] wv,
                                              input logic [1:0]  size);
    logic [31:0] res;
    case (size)
      2'b00:   res = {rdata[31:8], wv[7:0]};
      2'b01:   res = {rdata[31:16], wv[15:0]};
      2'b10:   res = wv;
      default: res = rdata;
    endcase
    return res;
  endfunction

  // Handshake and write strobe decode; the strobe is killed during reset so
  // an abandoned read-modify-write never reaches memory.
  always_comb begin
    o_req_ready = (state_r == IDLE);
    if (i_rst) begin
      o_mem_wr_en = 1'b0;
    end else begin
      o_mem_wr_en = (state_r == WRITE);
    end
  end

  // Request FSM with registered response and memory outputs. The read word
  // is consumed at the READ edge, both for load extension and store merge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= IDLE;
      wr_r         <= 1'b0;
      size_r       <= 2'd0;
      uns_r        <= 1'b0;
      wv_r         <= 32'd0;
      o_rsp_valid  <= 1'b0;
      o_rsp_val    <= 32'd0;
      o_rsp_err    <= 1'b0;
      o_mem_addr   <= {ADDR_WIDTH{1'b0}};
      o_mem_wr_val <= 32'd0;
    end else begin
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_val   <= 32'd0;
      case (state_r)
        IDLE: begin
          if (i_req_valid) begin
            wr_r       <= i_req_wr;
            size_r     <= i_req_size;
            uns_r      <= i_req_unsigned;
            wv_r       <= i_req_wr_val;
            o_mem_addr <= i_req_addr;
            if (i_req_size == 2'b11) begin
              state_r     <= RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
            end else if (i_req_wr && (i_req_size == 2'b10)) begin
              state_r      <= WRITE;
              o_mem_wr_val <= i_req_wr_val;
            end else begin
              state_r <= READ;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          if (wr_r) begin
            state_r      <= WRITE;
            o_mem_wr_val <= merge_store(i_mem_val, wv_r, size_r);
          end else begin
            state_r     <= RESP;
            o_rsp_valid <= 1'b1;
            o_rsp_val   <= extend_load(i_mem_val, size_r, uns_r);
          end
        end
        WRITE: begin
          state_r     <= RESP;
          o_rsp_valid <= 1'b1;
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of requests with expected
// results fed through a scoreboard, plus back-to-back and mid-op reset cases.
module tb_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_wr;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic [31:0] i_req_wr_val;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_val;
  logic        o_rsp_err;
  logic [31:0] o_mem_addr;
  logic        o_mem_wr_en;
  logic [31:0] o_mem_wr_val;
  logic [31:0] i_mem_val;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_wr(i_req_wr), .i_req_size(i_req_size),
    .i_req_unsigned(i_req_unsigned), .i_req_wr_val(i_req_wr_val),
    .o_rsp_valid(o_rsp_valid), .o_rsp_val(o_rsp_val), .o_rsp_err(o_rsp_err),
    .o_mem_addr(o_mem_addr), .o_mem_wr_en(o_mem_wr_en),
    .o_mem_wr_val(o_mem_wr_val), .i_mem_val(i_mem_val)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wv;
    logic [31:0] exp_val;
    logic        exp_err;
    int          exp_lat;
    int          exp_nwr;
    logic [31:0] exp_wdata;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  vec_t sb_q[$];
  int   acc_q[$];

  // byte-addressed memory model, 4 KiB, wraps on 12 bits
  logic [7:0] mem [0:4095];
  logic [11:0] ma;

  always_comb begin
    ma = o_mem_addr[11:0];
    i_mem_val = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};
  end

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_mem_wr_en) begin
      mem[ma]          = o_mem_wr_val[7:0];
      mem[ma + 12'd1]  = o_mem_wr_val[15:8];
      mem[ma + 12'd2]  = o_mem_wr_val[23:16];
      mem[ma + 12'd3]  = o_mem_wr_val[31:24];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor: acceptance, writes and responses, sampled mid-cycle
  int          nwr = 0;
  int          wcyc = 0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] waddr = 32'd0;

  always begin
    vec_t v;
    int   acc;
    @(negedge i_clk);
    #1;
    if (!i_rst && i_req_valid && o_req_ready) acc_q.push_back(cyc);
    if (o_mem_wr_en) begin
      nwr++;
      wcyc  = cyc;
      wdata = o_mem_wr_val;
      waddr = o_mem_addr;
    end
    if (o_rsp_valid) begin
      if (sb_q.size() == 0 || acc_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        v   = sb_q.pop_front();
        acc = acc_q.pop_front();
        check("rsp_val", o_rsp_val, v.exp_val);
        check("rsp_err", {31'd0, o_rsp_err}, {31'd0, v.exp_err});
        check("rsp_lat", cyc - acc, v.exp_lat);
        check("num_writes", nwr, v.exp_nwr);
        if (v.exp_nwr > 0) begin
          check("wr_data", wdata, v.exp_wdata);
          check("wr_addr", waddr, v.addr);
          check("wr_lat", wcyc - acc, v.exp_lat - 1);
        end
      end
      nwr = 0;
    end
  end

  function automatic vec_t mk(input logic [31:0] addr, input logic wr,
                              input logic [1:0] size, input logic uns,
                              input logic [31:0] wv, input logic [31:0] ev,
                              input logic ee, input int lat, input int nw,
                              input logic [31:0] ewd);
    vec_t v;
    v.addr = addr; v.wr = wr; v.size = size; v.uns = uns; v.wv = wv;
    v.exp_val = ev; v.exp_err = ee; v.exp_lat = lat; v.exp_nwr = nw;
    v.exp_wdata = ewd;
    return v;
  endfunction

  task automatic drive_fields(input vec_t v);
    i_req_addr     = v.addr;
    i_req_wr       = v.wr;
    i_req_size     = v.size;
    i_req_unsigned = v.uns;
    i_req_wr_val   = v.wv;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 50) begin
      @(negedge i_clk);
      guard++;
    end
    if (sb_q.size() != 0) begin
      check("rsp_timeout", 32'd1, 32'd0);
      sb_q.delete();
      acc_q.delete();
    end
    @(negedge i_clk);
  endtask

  task automatic run_vec(input vec_t v);
    int guard = 0;
    sb_q.push_back(v);
    drive_fields(v);
    i_req_valid = 1'b1;
    while (!o_req_ready && guard < 20) begin
      @(negedge i_clk);
      guard++;
    end
    if (!o_req_ready) check("accept_timeout", 32'd1, 32'd0);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    wait_drain();
  endtask

  function automatic void put_word(input int a, input logic [31:0] w);
    mem[a]     = w[7:0];
    mem[a + 1] = w[15:8];
    mem[a + 2] = w[23:16];
    mem[a + 3] = w[31:24];
  endfunction

  vec_t vecs[17];

  initial begin
    int c1, c2, low, guard;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    put_word(32'h100, 32'h80FF7F01);
    put_word(32'h300, 32'h11223344);
    put_word(32'h400, 32'h55667788);
    put_word(32'h500, 32'h12345678);

    //            addr       wr    size   uns   wv            exp_val       err   lat nwr wdata
    vecs[0]  = mk(32'h102, 1'b0, 2'b00, 1'b0, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 0, 32'h0);
    vecs[1]  = mk(32'h102, 1'b0, 2'b00, 1'b1, 32'h0,        32'h000000FF, 1'b0, 2, 0, 32'h0);
    vecs[2]  = mk(32'h102, 1'b0, 2'b01, 1'b0, 32'h0,        32'hFFFF80FF, 1'b0, 2, 0, 32'h0);
    vecs[3]  = mk(32'h101, 1'b0, 2'b01, 1'b1, 32'h0,        32'h0000FF7F, 1'b0, 2, 0, 32'h0);
    vecs[4]  = mk(32'h100, 1'b0, 2'b00, 1'b0, 32'h0,        32'h00000001, 1'b0, 2, 0, 32'h0);
    vecs[5]  = mk(32'h101, 1'b1, 2'b00, 1'b0, 32'h123456AB, 32'h0,        1'b0, 3, 1, 32'h0080FFAB);
    vecs[6]  = mk(32'h100, 1'b0, 2'b10, 1'b0, 32'h0,        32'h80FFAB01, 1'b0, 2, 0, 32'h0);
    vecs[7]  = mk(32'h200, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF);
    vecs[8]  = mk(32'h200, 1'b0, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'h0);
    vecs[9]  = mk(32'h202, 1'b0, 2'b01, 1'b1, 32'h0,        32'h0000DEAD, 1'b0, 2, 0, 32'h0);
    vecs[10] = mk(32'h200, 1'b0, 2'b01, 1'b0, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 0, 32'h0);
    vecs[11] = mk(32'h200, 1'b1, 2'b11, 1'b0, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0);
    vecs[12] = mk(32'h200, 1'b0, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'h0);
    vecs[13] = mk(32'h300, 1'b1, 2'b01, 1'b0, 32'hAAAA5555, 32'h0,        1'b0, 3, 1, 32'h11225555);
    vecs[14] = mk(32'h300, 1'b0, 2'b10, 1'b0, 32'h0,        32'h11225555, 1'b0, 2, 0, 32'h0);
    vecs[15] = mk(32'h201, 1'b1, 2'b10, 1'b0, 32'h01020304, 32'h0,        1'b0, 2, 1, 32'h01020304);
    vecs[16] = mk(32'h200, 1'b0, 2'b10, 1'b0, 32'h0,        32'h020304EF, 1'b0, 2, 0, 32'h0);

    i_rst = 1'b1;
    i_req_valid = 1'b0;
    i_req_addr = 32'd0; i_req_wr = 1'b0; i_req_size = 2'd0;
    i_req_unsigned = 1'b0; i_req_wr_val = 32'd0;
    repeat (3) @(negedge i_clk);
    check("rst_wr_en", {31'd0, o_mem_wr_en}, 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_ready", {31'd0, o_req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("rst_rsp_val", o_rsp_val, 32'd0);
    check("rst_mem_addr", o_mem_addr, 32'd0);
    check("rst_mem_wr_val", o_mem_wr_val, 32'd0);

    for (int i = 0; i < 17; i++) run_vec(vecs[i]);

    // back-to-back sub-word stores with valid held high
    sb_q.push_back(mk(32'h400, 1'b1, 2'b00, 1'b0, 32'h000000AA, 32'h0, 1'b0, 3, 1, 32'h556677AA));
    sb_q.push_back(mk(32'h401, 1'b1, 2'b00, 1'b0, 32'h000000BB, 32'h0, 1'b0, 3, 1, 32'h005566BB));
    i_req_addr = 32'h400; i_req_wr = 1'b1; i_req_size = 2'b00;
    i_req_unsigned = 1'b0; i_req_wr_val = 32'h000000AA;
    i_req_valid = 1'b1;
    c1 = cyc;
    @(negedge i_clk);
    i_req_addr = 32'h401; i_req_wr_val = 32'h000000BB;
    low = 0; guard = 0;
    while (!o_req_ready && guard < 20) begin
      low++;
      guard++;
      @(negedge i_clk);
    end
    c2 = cyc;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    check("b2b_accept_gap", c2 - c1, 32'd4);
    check("b2b_ready_low", low, 32'd3);
    wait_drain();
    run_vec(mk(32'h400, 1'b0, 2'b10, 1'b0, 32'h0, 32'h5566BBAA, 1'b0, 2, 0, 32'h0));

    // halfword store abandoned by reset in its WRITE cycle
    i_req_addr = 32'h500; i_req_wr = 1'b1; i_req_size = 2'b01;
    i_req_unsigned = 1'b0; i_req_wr_val = 32'h0000CAFE;
    i_req_valid = 1'b1;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    @(negedge i_clk);
    check("rmw_in_write", {31'd0, o_mem_wr_en}, 32'd1);
    i_rst = 1'b1;
    #1;
    check("rst_kills_write", {31'd0, o_mem_wr_en}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    acc_q.delete();
    nwr = 0;
    check("post_rst_ready", {31'd0, o_req_ready}, 32'd1);
    check("post_rst_rsp", {31'd0, o_rsp_valid}, 32'd0);
    check("post_rst_mem_addr", o_mem_addr, 32'd0);
    repeat (4) @(negedge i_clk);
    run_vec(mk(32'h500, 1'b0, 2'b10, 1'b0, 32'h0, 32'h12345678, 1'b0, 2, 0, 32'h0));

    check("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
